mod_unit_arbiter: RTL and testbench

MOD_UNIT_ARBITER -- requirements
Module: mod_unit_arbiter

---
 rtl/mod_unit_arbiter.sv | 268 ++++++++++++++++++++++++++
 tb/tb_mod_unit_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_unit_arbiter.sv
// Round-robin arbiter that feeds one requester at a time into a set of
// modular arithmetic units, with a finish timeout and a held response phase.
module mod_unit_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    input  logic [2*NUM_REQ-1:0]   req_op_i,
    input  logic [64*NUM_REQ-1:0]  req_a_i,
    input  logic [64*NUM_REQ-1:0]  req_b_i,
    output logic [NUM_REQ-1:0]     resp_valid_o,
    input  logic [NUM_REQ-1:0]     resp_ready_i,
    output logic [63:0]            resp_data_o,
    output logic                   resp_err_o,
    output logic                   add_start_o,
    output logic                   sub_start_o,
    output logic                   mul_start_o,
    output logic                   inv_start_o,
    output logic [63:0]            a_o,
    output logic [63:0]            b_o,
    input  logic                   add_finish_i,
    input  logic                   sub_finish_i,
    input  logic                   mul_finish_i,
    input  logic                   inv_finish_i,
    input  logic [63:0]            add_result_i,
    input  logic [63:0]            sub_result_i,
    input  logic [63:0]            mul_result_i,
    input  logic [63:0]            inv_result_i
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [IW-1:0] LAST_RST = IW'(NUM_REQ - 1);
    localparam logic [1:0]    OP_ADD   = 2'b00;
    localparam logic [1:0]    OP_SUB   = 2'b01;
    localparam logic [1:0]    OP_MUL   = 2'b10;
    localparam logic [1:0]    OP_INV   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic logic [3:0] op_onehot(input logic [1:0] op);
        logic [3:0] oh;
        case (op)
            OP_ADD:  oh = 4'b0001;
            OP_SUB:  oh = 4'b0010;
            OP_MUL:  oh = 4'b0100;
            OP_INV:  oh = 4'b1000;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

    state_e               state_r;
    state_e               state_s;
    logic [IW-1:0]        last_grant_r;
    logic [IW-1:0]        gnt_r;
    logic [1:0]           op_r;
    logic [63:0]          a_r;
    logic [63:0]          b_r;
    logic [63:0]          data_r;
    logic                 err_r;
    logic [CW-1:0]        cnt_r;
    logic [CW-1:0]        cnt_s;
    logic [3:0]           start_r;
    logic [NUM_REQ-1:0]   resp_valid_r;

    logic [IW:0]          idx_s;
    logic [IW-1:0]        grant_idx_s;
    logic                 grant_vld_s;
    logic [1:0]           op_in_s;
    logic [63:0]          a_in_s;
    logic [63:0]          b_in_s;
    logic [1:0]           op_nx_s;
    logic                 fin_sel_s;
    logic [63:0]          res_sel_s;
    logic                 load_s;
    logic                 done_s;
    logic                 tmo_s;
    logic                 ack_s;

    // Circular first-set search starting just after the last served requester.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_idx_s = '0;
        idx_s       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_s = {1'b0, last_grant_r} + (IW+1)'(k + 1);
            if (idx_s >= (IW+1)'(NUM_REQ)) begin
                idx_s = idx_s - (IW+1)'(NUM_REQ);
            end else begin
                idx_s = idx_s;
            end
            if (!grant_vld_s && req_valid_i[idx_s[IW-1:0]]) begin
                grant_vld_s = 1'b1;
                grant_idx_s = idx_s[IW-1:0];
            end else begin
                grant_vld_s = grant_vld_s;
            end
        end
    end

    // Select the granted requester's op and operands.
    always_comb begin
        op_in_s = 2'b00;
        a_in_s  = 64'd0;
        b_in_s  = 64'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx_s == IW'(i)) begin
                op_in_s = req_op_i[2*i +: 2];
                a_in_s  = req_a_i[64*i +: 64];
                b_in_s  = req_b_i[64*i +: 64];
            end else begin
                op_in_s = op_in_s;
            end
        end
    end

    // Only the unit matching the latched op may complete the operation.
    always_comb begin
        case (op_r)
            OP_ADD: begin
                fin_sel_s = add_finish_i;
                res_sel_s = add_result_i;
            end
            OP_SUB: begin
                fin_sel_s = sub_finish_i;
                res_sel_s = sub_result_i;
            end
            OP_MUL: begin
                fin_sel_s = mul_finish_i;
                res_sel_s = mul_result_i;
            end
            OP_INV: begin
                fin_sel_s = inv_finish_i;
                res_sel_s = inv_result_i;
            end
            default: begin
                fin_sel_s = 1'b0;
                res_sel_s = 64'd0;
            end
        endcase
    end

    // Grant acknowledge is combinational and only offered while idle.
    always_comb begin
        if (rst_ni && (state_r == ST_IDLE) && grant_vld_s) begin
            req_ready_o = NUM_REQ'(1) << grant_idx_s;
        end else begin
            req_ready_o = '0;
        end
    end

    // Next-state and event decode; a finish beats the timeout in the same cycle.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        load_s  = 1'b0;
        done_s  = 1'b0;
        tmo_s   = 1'b0;
        ack_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (grant_vld_s) begin
                    state_s = ST_BUSY;
                    load_s  = 1'b1;
                    cnt_s   = '0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (fin_sel_s) begin
                    state_s = ST_RESP;
                    done_s  = 1'b1;
                end else if (cnt_r >= CNT_LAST) begin
                    state_s = ST_RESP;
                    tmo_s   = 1'b1;
                end else begin
                    cnt_s   = cnt_r + CW'(1);
                end
            end
            ST_RESP: begin
                if (resp_ready_i[gnt_r]) begin
                    state_s = ST_IDLE;
                    ack_s   = 1'b1;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    assign op_nx_s = load_s ? op_in_s : op_r;

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operation context, result capture and round-robin pointer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_r        <= '0;
            op_r         <= 2'b00;
            a_r          <= 64'd0;
            b_r          <= 64'd0;
            gnt_r        <= '0;
            data_r       <= 64'd0;
            err_r        <= 1'b0;
            last_grant_r <= LAST_RST;
        end else begin
            cnt_r <= cnt_s;
            if (load_s) begin
                op_r  <= op_in_s;
                a_r   <= a_in_s;
                b_r   <= (op_in_s == OP_INV) ? 64'd0 : b_in_s;
                gnt_r <= grant_idx_s;
            end
            if (done_s) begin
                data_r <= res_sel_s;
                err_r  <= 1'b0;
            end else if (tmo_s) begin
                data_r <= 64'd0;
                err_r  <= 1'b1;
            end
            if (ack_s) begin
                last_grant_r <= gnt_r;
            end
        end
    end

    // Unit starts and response valids are registered from the next state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            start_r      <= 4'b0000;
            resp_valid_r <= '0;
        end else begin
            start_r      <= (state_s == ST_BUSY) ? op_onehot(op_nx_s) : 4'b0000;
            resp_valid_r <= (state_s == ST_RESP) ? (NUM_REQ'(1) << gnt_r) : '0;
        end
    end

    assign add_start_o  = start_r[0];
    assign sub_start_o  = start_r[1];
    assign mul_start_o  = start_r[2];
    assign inv_start_o  = start_r[3];
    assign a_o          = a_r;
    assign b_o          = b_r;
    assign resp_valid_o = resp_valid_r;
    assign resp_data_o  = data_r;
    assign resp_err_o   = err_r;

endmodule

// File: tb/tb_mod_unit_arbiter.sv
// Randomised bench for mod_unit_arbiter: the bench plays requesters and units
// and predicts grants, results, latency and timeouts from a transaction model.
module tb_mod_unit_arbiter;

    localparam int N   = 4;
    localparam int TMO = 16;

    logic             clk;
    logic             rst_ni;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [2*N-1:0]   req_op;
    logic [64*N-1:0]  req_a;
    logic [64*N-1:0]  req_b;
    logic [N-1:0]     resp_valid;
    logic [N-1:0]     resp_ready;
    logic [63:0]      resp_data;
    logic             resp_err;
    logic             add_start, sub_start, mul_start, inv_start;
    logic [63:0]      a_out, b_out;
    logic             add_fin, sub_fin, mul_fin, inv_fin;
    logic [63:0]      add_res, sub_res, mul_res, inv_res;
    logic [3:0]       start_vec;

    int total;
    int bad;
    int last_g;

    assign start_vec = {inv_start, mul_start, sub_start, add_start};

    mod_unit_arbiter #(.NUM_REQ(N), .TIMEOUT(TMO)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_op_i     (req_op),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_data_o  (resp_data),
        .resp_err_o   (resp_err),
        .add_start_o  (add_start),
        .sub_start_o  (sub_start),
        .mul_start_o  (mul_start),
        .inv_start_o  (inv_start),
        .a_o          (a_out),
        .b_o          (b_out),
        .add_finish_i (add_fin),
        .sub_finish_i (sub_fin),
        .mul_finish_i (mul_fin),
        .inv_finish_i (inv_fin),
        .add_result_i (add_res),
        .sub_result_i (sub_res),
        .mul_result_i (mul_res),
        .inv_result_i (inv_res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] mask, input int last);
        for (int k = 1; k <= N; k++) begin
            if (mask[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [63:0] unit_calc(input logic [1:0] op, input logic [63:0] a,
                                              input logic [63:0] b);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a * b;
            default: return ~a ^ 64'h5a5a_0f0f_3c3c_a5a5;
        endcase
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic set_unit(input int u, input logic f, input logic [63:0] r);
        case (u)
            0: begin add_fin = f; add_res = r; end
            1: begin sub_fin = f; sub_res = r; end
            2: begin mul_fin = f; mul_res = r; end
            default: begin inv_fin = f; inv_res = r; end
        endcase
    endtask

    task automatic clear_units();
        for (int u = 0; u < 4; u++) set_unit(u, 1'b0, rnd64());
    endtask

    // One complete request/busy/response transaction with a model of the outcome.
    task automatic do_txn(input logic [N-1:0] mask, input logic [2*N-1:0] ops,
                          input logic [64*N-1:0] av, input logic [64*N-1:0] bv,
                          input int d, input int bp, input bit spur);
        int          g, nbusy, u;
        logic [1:0]  op;
        logic [63:0] a, b, expd;
        logic        experr;
        g      = rr_pick(mask, last_g);
        op     = ops[2*g +: 2];
        a      = av[64*g +: 64];
        b      = bv[64*g +: 64];
        experr = (d > TMO);
        nbusy  = experr ? TMO : d;
        expd   = experr ? 64'd0 : unit_calc(op, a, b);

        @(negedge clk);
        req_valid = mask; req_op = ops; req_a = av; req_b = bv;
        resp_ready = '0;
        clear_units();
        #1;
        check_val("grant", 64'(req_ready), 64'(1) << g);
        check_val("idle_rvalid", 64'(resp_valid), 64'd0);
        check_val("idle_start", 64'(start_vec), 64'd0);

        for (int n = 1; n <= nbusy; n++) begin
            @(negedge clk);
            req_valid = N'($urandom());
            clear_units();
            if (spur) begin
                u = (int'(op) + 1 + int'($urandom_range(0, 2))) % 4;
                set_unit(u, 1'b1, 64'd99);
            end
            if (n == d) set_unit(int'(op), 1'b1, expd);
            #1;
            check_val("busy_start", 64'(start_vec), 64'(1) << op);
            check_val("busy_a", a_out, a);
            check_val("busy_b", b_out, (op == 2'b11) ? 64'd0 : b);
            check_val("busy_ready", 64'(req_ready), 64'd0);
            check_val("busy_rvalid", 64'(resp_valid), 64'd0);
        end

        for (int m = 0; m <= bp; m++) begin
            @(negedge clk);
            req_valid = N'($urandom()) | N'(1);
            for (int v = 0; v < 4; v++) set_unit(v, 1'($urandom()), rnd64());
            resp_ready    = N'($urandom());
            resp_ready[g] = (m == bp);
            #1;
            check_val("resp_valid", 64'(resp_valid), 64'(1) << g);
            check_val("resp_data", resp_data, expd);
            check_val("resp_err", 64'(resp_err), 64'(experr));
            check_val("resp_start", 64'(start_vec), 64'd0);
            check_val("resp_ready", 64'(req_ready), 64'd0);
        end
        last_g = g;
    endtask

    // Grant a MUL, let it run a few cycles, then reset it away asynchronously.
    task automatic reset_mid_busy();
        logic [64*N-1:0] av, bv;
        av = '0; bv = '0;
        av[64 +: 64] = 64'd9; bv[64 +: 64] = 64'd3;
        @(negedge clk);
        req_valid = 4'b0010; req_op = 8'b0000_1000; req_a = av; req_b = bv;
        resp_ready = '0;
        clear_units();
        #1;
        check_val("rst_grant", 64'(req_ready), 64'd2);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            req_valid = '0;
            #1;
            check_val("rst_busy_start", 64'(start_vec), 64'b0100);
        end
        @(negedge clk);
        req_valid = 4'b0011;
        #2;
        rst_ni = 1'b0;
        #1;
        check_val("rst_start", 64'(start_vec), 64'd0);
        check_val("rst_rvalid", 64'(resp_valid), 64'd0);
        check_val("rst_a", a_out, 64'd0);
        check_val("rst_b", b_out, 64'd0);
        check_val("rst_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        rst_ni = 1'b1;
        req_valid = '0;
        last_g = N - 1;
        #1;
        check_val("post_rst_rvalid", 64'(resp_valid), 64'd0);
        check_val("post_rst_start", 64'(start_vec), 64'd0);
    endtask

    initial begin
        logic [64*N-1:0] av, bv;
        logic [2*N-1:0]  ops;
        logic [N-1:0]    mask;
        int              d;
        total = 0; bad = 0; last_g = N - 1;
        rst_ni = 1'b0;
        req_valid = '0; req_op = '0; req_a = '0; req_b = '0; resp_ready = '0;
        clear_units();
        repeat (2) @(negedge clk);
        #1;
        check_val("reset_start", 64'(start_vec), 64'd0);
        check_val("reset_rvalid", 64'(resp_valid), 64'd0);
        check_val("reset_data", resp_data, 64'd0);
        check_val("reset_err", 64'(resp_err), 64'd0);
        check_val("reset_a", a_out, 64'd0);
        check_val("reset_b", b_out, 64'd0);
        check_val("reset_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        rst_ni = 1'b1;

        // Round robin with everyone requesting: 0,1,2,3,0.
        for (int t = 0; t < 5; t++) begin
            for (int i = 0; i < N; i++) begin
                av[64*i +: 64] = rnd64();
                bv[64*i +: 64] = rnd64();
            end
            do_txn(4'b1111, 8'($urandom()), av, bv, int'($urandom_range(1, 5)), 0, 1'b0);
            check_val("rr_order", 64'(last_g), 64'((t + 1) % N == 0 ? N - 1 : t % N));
        end

        // Single MUL 5*7 finishing after 6 cycles.
        av = '0; bv = '0;
        av[128 +: 64] = 64'd5; bv[128 +: 64] = 64'd7;
        do_txn(4'b0100, 8'b0010_0000, av, bv, 6, 0, 1'b0);
        check_val("mul_35", unit_calc(2'b10, 64'd5, 64'd7), 64'd35);

        // INV that never finishes, then a finish exactly on the last cycle.
        av = '0; bv = '0;
        av[64 +: 64] = 64'h1234; bv[64 +: 64] = 64'h77;
        do_txn(4'b0010, 8'b0000_1100, av, bv, TMO + 5, 1, 1'b0);
        do_txn(4'b0010, 8'b0000_1100, av, bv, TMO, 0, 1'b0);
        do_txn(4'b0010, 8'b0000_1100, av, bv, TMO + 1, 0, 1'b0);

        // ADD 5+7 with spurious finishes from other units.
        av = '0; bv = '0;
        av[0 +: 64] = 64'd5; bv[0 +: 64] = 64'd7;
        do_txn(4'b0001, 8'b0000_0000, av, bv, 4, 0, 1'b1);

        // Long backpressure.
        do_txn(4'b1000, 8'b0100_0000, av, bv, 3, 10, 1'b0);

        // Reset mid-BUSY, then requester 0 beats 1.
        reset_mid_busy();
        do_txn(4'b0011, 8'b0000_0101, av, bv, 2, 0, 1'b0);
        check_val("post_rst_winner", 64'(last_g), 64'd0);

        // Randomised traffic.
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < N; i++) begin
                av[64*i +: 64] = rnd64();
                bv[64*i +: 64] = rnd64();
            end
            ops  = 8'($urandom());
            mask = N'($urandom_range(1, (1 << N) - 1));
            d    = int'($urandom_range(1, TMO + 3));
            do_txn(mask, ops, av, bv, d, int'($urandom_range(0, 3)), 1'($urandom()));
        end

        @(negedge clk);
        req_valid = '0; resp_ready = '0;
        clear_units();
        #1;
        check_val("final_rvalid", 64'(resp_valid), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
